// File: rtl/pipe_hazard_ctrl.sv
// Hazard scheduler for the 6-stage pipeline: tracks EX/MEM/WB destinations and
// drives stall, bubble, flush, hold and forwarding selects for the RF instruction.
module pipe_hazard_ctrl #(
   parameter int MUL_LAT = 3,
   parameter int REG_AW  = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              rf_valid_i,
   input  logic [REG_AW-1:0] rf_rs_i,
   input  logic [REG_AW-1:0] rf_rt_i,
   input  logic              rf_use_rs_i,
   input  logic              rf_use_rt_i,
   input  logic [REG_AW-1:0] rf_rd_i,
   input  logic              rf_wr_i,
   input  logic              rf_is_load_i,
   input  logic              rf_is_mul_i,
   input  logic              ex_branch_taken_i,
   output logic              stall_front_o,
   output logic              bubble_ex_o,
   output logic              flush_front_o,
   output logic              hold_all_o,
   output logic [1:0]        fwd_a_o,
   output logic [1:0]        fwd_b_o
);

   localparam int CNT_W = $clog2(MUL_LAT) + 1;
   localparam logic [CNT_W-1:0] MCNT_LAST = CNT_W'(MUL_LAT - 1);

   typedef struct packed {
      logic              valid;
      logic              wr;
      logic [REG_AW-1:0] dest;
      logic              isLoad;
      logic              isMul;
   } slot_t;

   slot_t exSlot_q, memSlot_q, wbSlot_q;
   slot_t exSlot_d, memSlot_d, wbSlot_d;
   logic [CNT_W-1:0] mcnt_q, mcnt_d;

   logic  mulBusy, loadStall, issued;
   slot_t rfSlot;

   function automatic logic slotMatch(input slot_t s, input logic [REG_AW-1:0] r,
                                      input logic useBit);
      return s.valid & s.wr & (s.dest == r) & (r != '0) & useBit;
   endfunction

   // Nearest producer wins: EX, then MEM, then WB.
   function automatic logic [1:0] fwdSel(input slot_t ex, input slot_t mem, input slot_t wb,
                                         input logic [REG_AW-1:0] r, input logic useBit);
      if (slotMatch(ex, r, useBit))
         return 2'd1;
      else if (slotMatch(mem, r, useBit))
         return 2'd2;
      else if (slotMatch(wb, r, useBit))
         return 2'd3;
      return 2'd0;
   endfunction

   assign mulBusy = exSlot_q.valid & exSlot_q.isMul & (mcnt_q < MCNT_LAST);

   assign loadStall = rf_valid_i & (
        (slotMatch(exSlot_q,  rf_rs_i, rf_use_rs_i) & exSlot_q.isLoad)
      | (slotMatch(exSlot_q,  rf_rt_i, rf_use_rt_i) & exSlot_q.isLoad)
      | (slotMatch(memSlot_q, rf_rs_i, rf_use_rs_i) & memSlot_q.isLoad)
      | (slotMatch(memSlot_q, rf_rt_i, rf_use_rt_i) & memSlot_q.isLoad));

   assign issued = rf_valid_i & ~loadStall & ~ex_branch_taken_i;

   assign rfSlot = '{valid: 1'b1, wr: rf_wr_i, dest: rf_rd_i,
                     isLoad: rf_is_load_i, isMul: rf_is_mul_i};

   always_comb begin
      stall_front_o = 1'b0;
      bubble_ex_o   = 1'b0;
      flush_front_o = 1'b0;
      hold_all_o    = 1'b0;
      fwd_a_o       = fwdSel(exSlot_q, memSlot_q, wbSlot_q, rf_rs_i, rf_use_rs_i);
      fwd_b_o       = fwdSel(exSlot_q, memSlot_q, wbSlot_q, rf_rt_i, rf_use_rt_i);
      exSlot_d      = exSlot_q;
      memSlot_d     = memSlot_q;
      wbSlot_d      = wbSlot_q;
      mcnt_d        = mcnt_q;
      if (rst_i) begin
         flush_front_o = 1'b1;
         fwd_a_o       = 2'd0;
         fwd_b_o       = 2'd0;
      end else if (mulBusy) begin
         // A multiply still working in EX freezes everything, branches included.
         hold_all_o = 1'b1;
         mcnt_d     = mcnt_q + CNT_W'(1);
      end else begin
         if (ex_branch_taken_i) begin
            flush_front_o = 1'b1;
            bubble_ex_o   = 1'b1;
         end else if (loadStall) begin
            stall_front_o = 1'b1;
            bubble_ex_o   = 1'b1;
         end
         wbSlot_d  = memSlot_q;
         memSlot_d = exSlot_q;
         exSlot_d  = issued ? rfSlot : '0;
         mcnt_d    = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         exSlot_q  <= '0;
         memSlot_q <= '0;
         wbSlot_q  <= '0;
         mcnt_q    <= '0;
      end else begin
         exSlot_q  <= exSlot_d;
         memSlot_q <= memSlot_d;
         wbSlot_q  <= wbSlot_d;
         mcnt_q    <= mcnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by random traffic,
// all checked against an in-flight instruction history model.
module tb_pipe_hazard_ctrl;

   localparam int MUL_LAT = 3;
   localparam int REG_AW  = 5;

   logic clk = 1'b0;
   logic rst;
   logic rfValid, rfUseRs, rfUseRt, rfWr, rfIsLoad, rfIsMul, exBranchTaken;
   logic [REG_AW-1:0] rfRs, rfRt, rfRd;
   logic stallFront, bubbleEx, flushFront, holdAll;
   logic [1:0] fwdA, fwdB;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit valid;
      bit wr;
      int dest;
      bit isLoad;
      bit isMul;
   } ins_t;

   // history[0] is the instruction now in EX, [1] in MEM, [2] in WB
   ins_t history[$];
   int   mulElapsed;
   bit   expStall, expBubble, expFlush, expHold;
   int   expFwdA, expFwdB;
   bit   expBusy;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .REG_AW(REG_AW)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .rf_valid_i        (rfValid),
      .rf_rs_i           (rfRs),
      .rf_rt_i           (rfRt),
      .rf_use_rs_i       (rfUseRs),
      .rf_use_rt_i       (rfUseRt),
      .rf_rd_i           (rfRd),
      .rf_wr_i           (rfWr),
      .rf_is_load_i      (rfIsLoad),
      .rf_is_mul_i       (rfIsMul),
      .ex_branch_taken_i (exBranchTaken),
      .stall_front_o     (stallFront),
      .bubble_ex_o       (bubbleEx),
      .flush_front_o     (flushFront),
      .hold_all_o        (holdAll),
      .fwd_a_o           (fwdA),
      .fwd_b_o           (fwdB)
   );

   function automatic ins_t emptyIns();
      ins_t e;
      e.valid = 0; e.wr = 0; e.dest = 0; e.isLoad = 0; e.isMul = 0;
      return e;
   endfunction

   function automatic void clearModel();
      history.delete();
      for (int i = 0; i < 3; i++) history.push_back(emptyIns());
      mulElapsed = 0;
   endfunction

   function automatic bit produces(int i, int r, bit useBit);
      return useBit && r != 0 && history[i].valid && history[i].wr && history[i].dest == r;
   endfunction

   function automatic int nearestProducer(int r, bit useBit);
      for (int i = 0; i < 3; i++)
         if (produces(i, r, useBit)) return i + 1;
      return 0;
   endfunction

   function automatic bit loadTooYoung(int r, bit useBit);
      for (int i = 0; i < 2; i++)
         if (produces(i, r, useBit) && history[i].isLoad) return 1;
      return 0;
   endfunction

   function automatic void computeExpected();
      bit ls;
      expStall = 0; expBubble = 0; expFlush = 0; expHold = 0;
      expFwdA = 0; expFwdB = 0; expBusy = 0;
      if (rst) begin
         expFlush = 1;
         return;
      end
      expFwdA = nearestProducer(int'(rfRs), rfUseRs);
      expFwdB = nearestProducer(int'(rfRt), rfUseRt);
      ls = rfValid && (loadTooYoung(int'(rfRs), rfUseRs) || loadTooYoung(int'(rfRt), rfUseRt));
      expBusy = history[0].valid && history[0].isMul && (mulElapsed < MUL_LAT - 1);
      if (expBusy) expHold = 1;
      else if (exBranchTaken) begin expFlush = 1; expBubble = 1; end
      else if (ls) begin expStall = 1; expBubble = 1; end
   endfunction

   function automatic void updateModel();
      ins_t n;
      if (rst) begin
         clearModel();
      end else if (expBusy) begin
         mulElapsed++;
      end else begin
         n = emptyIns();
         if (rfValid && !expStall && !exBranchTaken) begin
            n.valid = 1; n.wr = rfWr; n.dest = int'(rfRd);
            n.isLoad = rfIsLoad; n.isMul = rfIsMul;
         end
         history.push_front(n);
         void'(history.pop_back());
         mulElapsed = 0;
      end
   endfunction

   task automatic expectVal(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input bit skipFwd);
      expectVal("stall_front", {1'b0, stallFront}, {1'b0, expStall});
      expectVal("bubble_ex",   {1'b0, bubbleEx},   {1'b0, expBubble});
      expectVal("flush_front", {1'b0, flushFront}, {1'b0, expFlush});
      expectVal("hold_all",    {1'b0, holdAll},    {1'b0, expHold});
      if (!skipFwd) begin
         expectVal("fwd_a", fwdA, 2'(expFwdA));
         expectVal("fwd_b", fwdB, 2'(expFwdB));
      end
   endtask

   // Drive one cycle of inputs, then compare at the falling edge.
   task automatic applyStimulus(input bit r, input bit v, input int rs, input int rt,
                                input bit urs, input bit urt, input int rd, input bit wr,
                                input bit ld, input bit ml, input bit br);
      rst = r; rfValid = v; rfRs = REG_AW'(rs); rfRt = REG_AW'(rt);
      rfUseRs = urs; rfUseRt = urt; rfRd = REG_AW'(rd); rfWr = wr;
      rfIsLoad = ld; rfIsMul = ml; exBranchTaken = br;
      @(negedge clk);
      computeExpected();
      checkOutput(expBusy);
   endtask

   task automatic tick();
      @(posedge clk);
      updateModel();
      #1;
   endtask

   initial begin
      clearModel();
      rst = 1; rfValid = 0; rfRs = '0; rfRt = '0; rfUseRs = 0; rfUseRt = 0;
      rfRd = '0; rfWr = 0; rfIsLoad = 0; rfIsMul = 0; exBranchTaken = 0;
      @(posedge clk); #1;

      // Reset held two cycles with a valid instruction present
      applyStimulus(1, 1, 3, 4, 1, 1, 5, 1, 0, 0, 0);
      expectVal("rst_flush", {1'b0, flushFront}, 2'd1);
      expectVal("rst_bubble", {1'b0, bubbleEx}, 2'd0);
      tick();
      applyStimulus(1, 1, 3, 4, 1, 1, 5, 1, 0, 0, 0);
      expectVal("rst_hold", {1'b0, holdAll}, 2'd0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      expectVal("post_rst_fwd_a", fwdA, 2'd0);
      expectVal("post_rst_fwd_b", fwdB, 2'd0);
      tick();

      // ALU chain on $3 at distances 1, 2, 3
      applyStimulus(0, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
      tick();
      applyStimulus(0, 1, 3, 4, 1, 1, 10, 1, 0, 0, 0);
      expectVal("alu_d1_fwd_a", fwdA, 2'd1);
      tick();
      applyStimulus(0, 1, 3, 4, 1, 1, 11, 1, 0, 0, 0);
      expectVal("alu_d2_fwd_a", fwdA, 2'd2);
      tick();
      applyStimulus(0, 1, 3, 4, 1, 1, 12, 1, 0, 0, 0);
      expectVal("alu_d3_fwd_a", fwdA, 2'd3);
      expectVal("alu_d3_stall", {1'b0, stallFront}, 2'd0);
      tick();

      // Load-use at distance 1 on rt
      applyStimulus(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
      tick();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 1, 1, 5, 0, 1, 13, 1, 0, 0, 0);
         expectVal("lu_stall", {1'b0, stallFront}, 2'd1);
         expectVal("lu_bubble", {1'b0, bubbleEx}, 2'd1);
         tick();
      end
      applyStimulus(0, 1, 1, 5, 0, 1, 13, 1, 0, 0, 0);
      expectVal("lu_release_stall", {1'b0, stallFront}, 2'd0);
      expectVal("lu_release_fwd_b", fwdB, 2'd3);
      tick();

      // $0 never hazards; unused operand never hazards
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      tick();
      applyStimulus(0, 1, 0, 0, 1, 1, 14, 1, 0, 0, 0);
      expectVal("r0_stall", {1'b0, stallFront}, 2'd0);
      expectVal("r0_fwd_a", fwdA, 2'd0);
      tick();
      applyStimulus(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
      tick();
      applyStimulus(0, 1, 7, 2, 0, 1, 15, 1, 0, 0, 0);
      expectVal("unused_stall", {1'b0, stallFront}, 2'd0);
      tick();

      // Taken branch overrides a load stall and squashes the RF instruction
      applyStimulus(0, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
      tick();
      applyStimulus(0, 1, 6, 6, 1, 1, 16, 1, 0, 0, 1);
      expectVal("br_flush", {1'b0, flushFront}, 2'd1);
      expectVal("br_bubble", {1'b0, bubbleEx}, 2'd1);
      expectVal("br_stall", {1'b0, stallFront}, 2'd0);
      tick();
      applyStimulus(0, 1, 16, 1, 1, 0, 17, 1, 0, 0, 0);
      expectVal("br_squashed_fwd_a", fwdA, 2'd0);
      tick();

      // Multiply holds MUL_LAT-1 cycles and ignores a branch meanwhile
      applyStimulus(0, 1, 1, 2, 0, 0, 8, 1, 0, 1, 0);
      tick();
      applyStimulus(0, 1, 8, 0, 1, 0, 18, 1, 0, 0, 0);
      expectVal("mul_hold1", {1'b0, holdAll}, 2'd1);
      tick();
      applyStimulus(0, 1, 8, 0, 1, 0, 18, 1, 0, 0, 1);
      expectVal("mul_hold2", {1'b0, holdAll}, 2'd1);
      expectVal("mul_hold2_flush", {1'b0, flushFront}, 2'd0);
      tick();
      applyStimulus(0, 1, 8, 0, 1, 0, 18, 1, 0, 0, 0);
      expectVal("mul_release_hold", {1'b0, holdAll}, 2'd0);
      expectVal("mul_release_fwd_a", fwdA, 2'd1);
      tick();

      // Random traffic, including occasional mid-run resets
      for (int n = 0; n < 400; n++) begin
         bit ld, ml;
         ld = ($urandom_range(0, 3) == 0);
         ml = !ld && ($urandom_range(0, 5) == 0);
         applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 1), $urandom_range(0, 1),
                       $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                       ld, ml, $urandom_range(0, 7) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
